// File: rtl/song_pkg.sv
// Shared definitions for the song reader: FSM state encoding, default field
// widths and the slice positions of the {note,duration} ROM word.
package song_pkg;

  localparam int SONG_BITS_DEF = 2;
  localparam int NOTE_BITS_DEF = 5;
  localparam int NOTE_W_DEF    = 6;
  localparam int DUR_W_DEF     = 6;

  // Duration occupies the low bits of the ROM word, pitch sits above it.
  localparam int DUR_LSB  = 0;
  localparam int NOTE_LSB = DUR_LSB + DUR_W_DEF;
  localparam int WORD_W   = NOTE_W_DEF + DUR_W_DEF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_PLAYING = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/song_addr_counter.sv
// Song index and note address registers. next_song outranks clear, which
// outranks inc; last flags the final note slot of a song.
module song_addr_counter
  import song_pkg::*;
#(
  parameter int SONG_BITS = SONG_BITS_DEF,
  parameter int NOTE_BITS = NOTE_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 inc,
  input  logic                 next_song,
  output logic [SONG_BITS-1:0] song,
  output logic [NOTE_BITS-1:0] note_addr,
  output logic                 last
);

  always_ff @(posedge clk) begin
    if (reset) begin
      song      <= '0;
      note_addr <= '0;
    end else begin
      if (next_song) song <= song + 1'b1;
      if (next_song || clear) note_addr <= '0;
      else if (inc)           note_addr <= note_addr + 1'b1;
    end
  end

  assign last = &note_addr;

endmodule

// File: rtl/song_reader.sv
// Note-fetch sequencer: reads {note,duration} words from a 1-cycle-latency
// song ROM and hands them to the note player one at a time.
// Optional build macro: SONG_LOOP_EN (song repeats instead of ending).
//
// Handshake: new_note is a 1-cycle pulse with note/duration already stable;
// the note player answers with a 1-cycle note_done pulse, after which the next
// word is fetched. There is no backpressure beyond play.
module song_reader
  import song_pkg::*;
#(
  parameter int SONG_BITS = SONG_BITS_DEF,
  parameter int NOTE_BITS = NOTE_BITS_DEF,
  parameter int NOTE_W    = NOTE_W_DEF,
  parameter int DUR_W     = DUR_W_DEF
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           play,
  input  logic                           reset_play,
  input  logic                           NextSong,
  input  logic                           note_done,
  input  logic [NOTE_W+DUR_W-1:0]        rom_data,
  output logic [SONG_BITS+NOTE_BITS-1:0] rom_addr,
  output logic [NOTE_W-1:0]              note,
  output logic [DUR_W-1:0]               duration,
  output logic                           new_note,
  output logic                           song_done,
  output logic [SONG_BITS-1:0]           song,
  output logic [2:0]                     dbg_state
);

  localparam int N_LSB = DUR_LSB + DUR_W;

  state_t                   state, state_nxt;
  logic [NOTE_BITS-1:0]     note_addr;
  logic                     cnt_last;
  logic                     cnt_clear, cnt_inc;
  logic                     load, hold;
  logic                     held;
  logic [NOTE_W+DUR_W-1:0]  hold_word;
  logic [NOTE_W+DUR_W-1:0]  word;
  logic                     restart;
  logic                     done_c;

  song_addr_counter #(
    .SONG_BITS(SONG_BITS),
    .NOTE_BITS(NOTE_BITS)
  ) u_cnt (
    .clk       (clk),
    .reset     (reset),
    .clear     (cnt_clear),
    .inc       (cnt_inc),
    .next_song (NextSong),
    .song      (song),
    .note_addr (note_addr),
    .last      (cnt_last)
  );

  // A word read while paused is parked here until play returns.
  assign word    = held ? hold_word : rom_data;
  assign restart = reset_play | NextSong;

  always_comb begin
    state_nxt = state;
    cnt_clear = 1'b0;
    cnt_inc   = 1'b0;
    load      = 1'b0;
    hold      = 1'b0;
    done_c    = 1'b0;
    case (state)
      ST_IDLE:  if (play) state_nxt = ST_FETCH;
      ST_FETCH: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (word[DUR_LSB +: DUR_W] == '0) begin
          state_nxt = ST_DONE;
        end else if (play) begin
          load      = 1'b1;
          state_nxt = ST_PLAYING;
        end else if (!held) begin
          hold = 1'b1;
        end
      end
      ST_PLAYING: begin
        if (note_done) begin
          if (cnt_last) begin
            cnt_clear = 1'b1;
            state_nxt = ST_DONE;
          end else begin
            cnt_inc   = 1'b1;
            state_nxt = play ? ST_FETCH : ST_IDLE;
          end
        end
      end
      ST_DONE: begin
        cnt_clear = 1'b1;
`ifdef SONG_LOOP_EN
        state_nxt = ST_FETCH;
`else
        done_c    = 1'b1;
        state_nxt = ST_IDLE;
`endif
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Restart wins over whatever the current state wanted to do.
    if (restart) begin
      state_nxt = ST_IDLE;
      cnt_clear = 1'b1;
      cnt_inc   = 1'b0;
      load      = 1'b0;
      hold      = 1'b0;
      done_c    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      note      <= '0;
      duration  <= '0;
      new_note  <= 1'b0;
      held      <= 1'b0;
      hold_word <= '0;
    end else begin
      state    <= state_nxt;
      new_note <= load;
      if (load) begin
        note     <= word[N_LSB +: NOTE_W];
        duration <= word[DUR_LSB +: DUR_W];
      end
      if (restart || load) begin
        held <= 1'b0;
      end else if (hold) begin
        held      <= 1'b1;
        hold_word <= rom_data;
      end
    end
  end

  assign rom_addr  = {song, note_addr};
  assign song_done = done_c;
  assign dbg_state = state;

endmodule

// File: tb/tb_song_reader.sv
// Directed bench for song_reader: a ROM-driven expectation queue checked on
// every new_note/song_done, plus literal checks for the scenario values.
module tb_song_reader;
  import song_pkg::*;

  logic        clk = 1'b0;
  logic        reset, play, reset_play, NextSong, note_done;
  logic [11:0] rom_data;
  logic [6:0]  rom_addr;
  logic [5:0]  note, duration;
  logic        new_note, song_done;
  logic [1:0]  song;
  logic [2:0]  dbg_state;

  logic [11:0] rom [0:127];
  logic [11:0] exp_q[$];
  logic [1:0]  done_q[$];
  logic [1:0]  m_song = 2'd0;
  logic [11:0] e_word;
  logic [1:0]  e_song;
  int          checks = 0;
  int          errors = 0;

  song_reader dut (
    .clk        (clk),
    .reset      (reset),
    .play       (play),
    .reset_play (reset_play),
    .NextSong   (NextSong),
    .note_done  (note_done),
    .rom_data   (rom_data),
    .rom_addr   (rom_addr),
    .note       (note),
    .duration   (duration),
    .new_note   (new_note),
    .song_done  (song_done),
    .song       (song),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  // Synchronous song ROM, one cycle of latency.
  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: each new_note must deliver the next queued ROM word, each
  // song_done must be expected, and the song index must follow the model.
  always @(negedge clk) begin
    if (!reset) begin
      chk("song_tracks_model", {30'd0, song}, {30'd0, m_song});
      chk("rom_addr_song_field", {30'd0, rom_addr[6:5]}, {30'd0, m_song});
      if (new_note) begin
        chk("new_note_without_song_done", {31'd0, song_done}, 32'd0);
        chk("new_note_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          e_word = exp_q.pop_front();
          chk("note_word", {20'd0, note, duration}, {20'd0, e_word});
        end
      end
      if (song_done) begin
        chk("song_done_expected", {31'd0, done_q.size() != 0}, 32'd1);
        if (done_q.size() != 0) begin
          e_song = done_q.pop_front();
          chk("song_done_song", {30'd0, song}, {30'd0, e_song});
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // kind 0: new_note, 1: song_done, 2: dbg_state == st. Returns at the negedge.
  task automatic wait_cond(input int kind, input logic [2:0] st, input int max_cyc,
                           input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      case (kind)
        0:       seen = new_note;
        1:       seen = song_done;
        default: seen = (dbg_state == st);
      endcase
    end
    chk(name, {31'd0, seen}, 32'd1);
  endtask

  task automatic pulse_note_done();
    @(posedge clk); #2 note_done = 1'b1;
    @(posedge clk); #2 note_done = 1'b0;
  endtask

  task automatic pulse_ctl(input logic ns, input logic rp);
    @(posedge clk); #2;
    NextSong   = ns;
    reset_play = rp;
    @(posedge clk); #2;
    NextSong   = 1'b0;
    reset_play = 1'b0;
    if (ns) m_song = m_song + 2'd1;
  endtask

  task automatic end_song(input logic [1:0] s);
`ifdef SONG_LOOP_EN
    exp_q.push_back(rom[{s, 5'd0}]);
    wait_cond(0, ST_IDLE, 8, "loop_restart_note");
    chk("loop_restart_addr", {25'd0, rom_addr}, {25'd0, s, 5'd0});
    play = 1'b0;
    pulse_ctl(1'b0, 1'b1);
`else
    done_q.push_back(s);
    wait_cond(1, ST_IDLE, 8, "song_done_seen");
    play = 1'b0;
    step(1);
    chk("rom_addr_after_done", {25'd0, rom_addr}, {25'd0, s, 5'd0});
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; play = 1'b0; reset_play = 1'b0; NextSong = 1'b0; note_done = 1'b0;
    for (int i = 0; i < 128; i++) rom[i] = 12'd0;
    rom[0]  = {6'd5, 6'd3};
    rom[1]  = {6'd7, 6'd2};
    rom[32] = {6'd1, 6'd1};
    rom[64] = {6'd9, 6'd4};
    rom[65] = {6'd11, 6'd5};
    for (int i = 0; i < 32; i++) rom[96 + i] = {6'(i + 1), 6'(i + 2)};

    step(3);
    @(negedge clk);
    chk("reset_rom_addr",  {25'd0, rom_addr}, 32'd0);
    chk("reset_note",      {26'd0, note}, 32'd0);
    chk("reset_duration",  {26'd0, duration}, 32'd0);
    chk("reset_new_note",  {31'd0, new_note}, 32'd0);
    chk("reset_song_done", {31'd0, song_done}, 32'd0);
    chk("reset_song",      {30'd0, song}, 32'd0);
    chk("reset_state",     {29'd0, dbg_state}, {29'd0, ST_IDLE});
    @(posedge clk); #2 reset = 1'b0;

    // Scenario 1: song 0 plays (5,3), (7,2), then ends.
    exp_q.push_back(rom[0]);
    exp_q.push_back(rom[1]);
    play = 1'b1;
    wait_cond(0, ST_IDLE, 8, "t1_first_note");
    chk("t1_note0", {26'd0, note}, 32'd5);
    chk("t1_dur0",  {26'd0, duration}, 32'd3);
    pulse_note_done();
    wait_cond(0, ST_IDLE, 8, "t1_second_note");
    chk("t1_note1", {26'd0, note}, 32'd7);
    chk("t1_dur1",  {26'd0, duration}, 32'd2);
    pulse_note_done();
    end_song(2'd0);

    // Scenario 2a: pause while PLAYING; note_done still accepted.
    exp_q.push_back(rom[0]);
    play = 1'b1;
    wait_cond(0, ST_IDLE, 8, "t2_first_note");
    play = 1'b0;
    pulse_note_done();
    step(5);
    chk("t2_paused_addr", {25'd0, rom_addr}, 32'd1);
    exp_q.push_back(rom[1]);
    play = 1'b1;
    wait_cond(2, ST_FETCH, 2, "t2_fetch_within_2");
    wait_cond(0, ST_IDLE, 4, "t2_resumed_note");
    chk("t2_note1", {26'd0, note}, 32'd7);
    pulse_note_done();
    end_song(2'd0);

    // Scenario 2b: pause during the ROM read defers new_note.
    play = 1'b1;
    wait_cond(2, ST_FETCH, 4, "t2b_fetch");
    play = 1'b0;
    step(4);
    chk("t2b_held_in_wait", {29'd0, dbg_state}, {29'd0, ST_WAIT});
    exp_q.push_back(rom[0]);
    play = 1'b1;
    wait_cond(0, ST_IDLE, 3, "t2b_deferred_note");
    play = 1'b0;
    pulse_ctl(1'b0, 1'b1);

    // Scenario 4: reset_play during WAIT cancels the note, refetches note 0.
    exp_q.push_back(rom[0]);
    play = 1'b1;
    wait_cond(0, ST_IDLE, 8, "t4_first_note");
    pulse_note_done();
    wait_cond(2, ST_WAIT, 4, "t4_reach_wait");
    reset_play = 1'b1;
    @(posedge clk); #2;
    reset_play = 1'b0;
    play = 1'b0;
    step(3);
    chk("t4_addr_cleared", {25'd0, rom_addr}, 32'd0);
    chk("t4_note_kept",    {26'd0, note}, 32'd5);
    chk("t4_dur_kept",     {26'd0, duration}, 32'd3);
    chk("t4_state_idle",   {29'd0, dbg_state}, {29'd0, ST_IDLE});
    exp_q.push_back(rom[0]);
    play = 1'b1;
    wait_cond(0, ST_IDLE, 8, "t4_refetch_note");
    chk("t4_refetch_addr0", {25'd0, rom_addr}, 32'd0);
    play = 1'b0;
    pulse_ctl(1'b0, 1'b1);

    // Scenario 3: song stepping, combined restart mid-note, later wrap.
    pulse_ctl(1'b1, 1'b0);
    chk("t3_song1",      {30'd0, song}, 32'd1);
    chk("t3_song1_addr", {25'd0, rom_addr}, 32'd32);
    pulse_ctl(1'b1, 1'b0);
    chk("t3_song2",      {30'd0, song}, 32'd2);
    exp_q.push_back(rom[64]);
    play = 1'b1;
    wait_cond(0, ST_IDLE, 8, "t3_song2_note");
    chk("t3_note9", {26'd0, note}, 32'd9);
    chk("t3_dur4",  {26'd0, duration}, 32'd4);
    play = 1'b0;
    pulse_ctl(1'b1, 1'b1);
    chk("t3_song3",      {30'd0, song}, 32'd3);
    chk("t3_song3_addr", {25'd0, rom_addr}, 32'd96);
    chk("t3_state_idle", {29'd0, dbg_state}, {29'd0, ST_IDLE});

    // Scenario 5: all 32 slots of song 3 play before the song ends.
    play = 1'b1;
    for (int i = 0; i < 32; i++) begin
      exp_q.push_back(rom[96 + i]);
      wait_cond(0, ST_IDLE, 8, "t5_note");
      chk("t5_rom_addr", {25'd0, rom_addr}, 32'(96 + i));
      pulse_note_done();
    end
    end_song(2'd3);

    pulse_ctl(1'b1, 1'b0);
    chk("t3_wrap_song",  {30'd0, song}, 32'd0);
    chk("t3_wrap_addr",  {25'd0, rom_addr}, 32'd0);

    step(3);
    chk("exp_q_drained",  32'(exp_q.size()), 32'd0);
    chk("done_q_drained", 32'(done_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
